// File: rtl/seg7_rx.sv
// seg7_rx: receiving end of the 7-segment digit link.
// Synchronizes an asynchronous active-low segment bus. Rejects patterns that
// are not stable for STABLE_CYCLES samples. Decodes each accepted pattern to
// a 4-bit code, 0..9 or 10 for the dash.
// Ports:
//   CLOCK_50    - system clock
//   KEY         - asynchronous active-low reset
//   SEG[6:0]    - segment bus, active-low, bit0=a .. bit6=g
//   digit       - last accepted legal code
//   digit_valid - one-cycle strobe per accepted legal code
//   blank       - accepted pattern is all-off
//   err         - sticky illegal-pattern flag, cleared by the next legal code
//   rx_count    - accepted legal codes, wrapping
module seg7_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic [6:0]       SEG,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic             err,
    output logic [CNT_W-1:0] rx_count
);

    localparam logic [6:0] BLANK_PAT = 7'b1111111;
    localparam logic [7:0] LAST      = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t           state, state_n;
    logic [6:0]       sync1, s;
    logic [6:0]       held, held_n;
    logic [6:0]       cand, cand_n;
    logic [7:0]       cnt, cnt_n;
    logic [3:0]       digit_n;
    logic             valid_n, blank_n, err_n;
    logic [CNT_W-1:0] rx_count_n;

    // Decode of the candidate. Only used at acceptance, when cand == s.
    logic [3:0] code;
    logic       legal;
    logic       is_blank;

    always_comb begin
        code     = 4'd0;
        legal    = 1'b1;
        is_blank = (cand == BLANK_PAT);
        case (cand)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b0111111: code = 4'd10;
            default:    legal = 1'b0;
        endcase
    end

    // Two-flop synchronizer. Every bit is a level that is held for many
    // cycles, so bits that resolve on different edges only look like a
    // bounce. The settle filter absorbs that bounce.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            sync1 <= BLANK_PAT;
            s     <= BLANK_PAT;
        end else begin
            sync1 <= SEG;
            s     <= sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state       <= IDLE;
            held        <= BLANK_PAT;
            cand        <= BLANK_PAT;
            cnt         <= 8'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b1;
            err         <= 1'b0;
            rx_count    <= '0;
        end else begin
            state       <= state_n;
            held        <= held_n;
            cand        <= cand_n;
            cnt         <= cnt_n;
            digit       <= digit_n;
            digit_valid <= valid_n;
            blank       <= blank_n;
            err         <= err_n;
            rx_count    <= rx_count_n;
        end
    end

    always_comb begin
        state_n    = state;
        held_n     = held;
        cand_n     = cand;
        cnt_n      = cnt;
        digit_n    = digit;
        valid_n    = 1'b0;
        blank_n    = blank;
        err_n      = err;
        rx_count_n = rx_count;
        case (state)
            IDLE, HOLD: begin
                if (s != held) begin
                    state_n = SETTLE;
                    cand_n  = s;
                    cnt_n   = 8'd1;
                end
            end
            SETTLE: begin
                if (s != cand) begin
                    // Any bounce restarts the stability count.
                    cand_n = s;
                    cnt_n  = 8'd1;
                end else if (cnt < LAST) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    // Settling back on the held pattern is a full acceptance.
                    // A repeated draw after a bounce therefore strobes again.
                    held_n = cand;
                    if (is_blank) begin
                        blank_n = 1'b1;
                        state_n = IDLE;
                    end else if (legal) begin
                        digit_n    = code;
                        valid_n    = 1'b1;
                        rx_count_n = rx_count + CNT_W'(1);
                        err_n      = 1'b0;
                        blank_n    = 1'b0;
                        state_n    = HOLD;
                    end else begin
                        err_n   = 1'b1;
                        blank_n = 1'b0;
                        state_n = HOLD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg7_rx.sv
// tb_seg7_rx: scoreboard bench for seg7_rx.
// Expected codes are queued when a pattern is driven. A negedge monitor pops
// the queue on each digit_valid and compares. Level outputs are checked
// directly against a small model count.
module tb_seg7_rx;

    logic       CLOCK_50 = 1'b0;
    logic       KEY;
    logic [6:0] SEG;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       err;
    logic [7:0] rx_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int q[$];

    localparam logic [6:0] P_BLANK = 7'b1111111;

    seg7_rx #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY         (KEY),
        .SEG         (SEG),
        .digit       (digit),
        .digit_valid (digit_valid),
        .blank       (blank),
        .err         (err),
        .rx_count    (rx_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Queue a code that must strobe, and advance the model count.
    task automatic expect_code(input int c);
        q.push_back(c);
        exp_cnt++;
    endtask

    // Assumes the caller is at a negedge.
    task automatic hold(input logic [6:0] p, input int n);
        SEG = p;
        repeat (n) @(negedge CLOCK_50);
    endtask

    always @(negedge CLOCK_50) begin
        if (digit_valid) begin
            if (q.size() == 0) chk("unexpected_strobe", 1, 0);
            else chk("strobe_digit", int'(digit), q.pop_front());
        end
    end

    initial begin
        KEY = 1'b0;
        SEG = 7'b0100100;
        repeat (4) @(negedge CLOCK_50);
        chk("rst_digit", digit, 0);
        chk("rst_blank", blank, 1);
        chk("rst_err", err, 0);
        chk("rst_cnt", rx_count, 0);
        chk("rst_valid", digit_valid, 0);

        // Release with 2 already on the bus: strobe after edge 6.
        KEY = 1'b1;
        expect_code(2);
        repeat (5) @(negedge CLOCK_50);
        chk("rel_early", digit_valid, 0);
        @(negedge CLOCK_50);
        chk("rel_t6", digit_valid, 1);
        @(negedge CLOCK_50);
        chk("rel_one_shot", digit_valid, 0);
        chk("rel_cnt", rx_count, exp_cnt);
        repeat (10) @(negedge CLOCK_50);

        // Clean digits
        hold(P_BLANK, 10);
        chk("blank_after", blank, 1);
        expect_code(7);
        hold(7'b1111000, 10);
        chk("d7_level", digit, 7);
        expect_code(9);
        hold(7'b0010000, 10);
        chk("clean_cnt", rx_count, exp_cnt);
        chk("clean_blank", blank, 0);

        // Glitch filter: three cycles of 4 are not enough.
        hold(P_BLANK, 10);
        hold(7'b0011001, 3);
        hold(P_BLANK, 10);
        chk("glitch_blank", blank, 1);
        chk("glitch_cnt", rx_count, exp_cnt);
        chk("glitch_digit", digit, 9);
        expect_code(4);
        hold(7'b0011001, 10);
        chk("d4_cnt", rx_count, exp_cnt);

        // Bounce between 5 and 6, then settle on 6.
        for (int i = 0; i < 5; i++)
            hold((i % 2 == 0) ? 7'b0010010 : 7'b0000010, 2);
        SEG = 7'b0000010;
        expect_code(6);
        repeat (5) @(negedge CLOCK_50);
        chk("bounce_early", digit_valid, 0);
        @(negedge CLOCK_50);
        chk("bounce_t6", digit_valid, 1);
        repeat (10) @(negedge CLOCK_50);
        chk("bounce_cnt", rx_count, exp_cnt);

        // Illegal pattern, then the dash.
        hold(7'b1010101, 12);
        chk("ill_err", err, 1);
        chk("ill_digit", digit, 6);
        chk("ill_blank", blank, 0);
        chk("ill_cnt", rx_count, exp_cnt);
        expect_code(10);
        hold(7'b0111111, 10);
        chk("dash_err", err, 0);
        chk("dash_digit", digit, 10);

        // Counter wrap: run up to a multiple of 256.
        begin
            int n;
            n = 256 - (exp_cnt % 256);
            for (int i = 0; i < n; i++) begin
                expect_code((i % 2 == 0) ? 1 : 2);
                hold((i % 2 == 0) ? 7'b1111001 : 7'b0100100, 7);
            end
        end
        repeat (4) @(negedge CLOCK_50);
        chk("wrap_cnt", rx_count, 0);
        chk("wrap_model", exp_cnt % 256, 0);

        // Asynchronous reset in the middle of SETTLE.
        SEG = 7'b0000000;
        repeat (3) @(negedge CLOCK_50);
        #2 KEY = 1'b0;
        #1;
        chk("arst_digit", digit, 0);
        chk("arst_blank", blank, 1);
        chk("arst_err", err, 0);
        chk("arst_cnt", rx_count, 0);
        chk("arst_valid", digit_valid, 0);
        exp_cnt = 0;
        repeat (4) @(negedge CLOCK_50);
        KEY = 1'b1;
        expect_code(8);
        repeat (10) @(negedge CLOCK_50);
        chk("arst_resume_cnt", rx_count, exp_cnt);

        chk("leftover", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
